// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared types and constants for the jump-target line table controller
// Purpose: controller state encoding, read-source tags and default geometry.
// Ports: none (package).
package lut_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } lut_state_e;

  localparam logic SRC_BR  = 1'b0;
  localparam logic SRC_DBG = 1'b1;

  localparam int LUT_ADDR_W = 8;
  localparam int LUT_DATA_W = 16;

endpackage

// File: rtl/lut_mem.sv
// rtl/lut_mem.sv - table storage with one synchronous write port and one registered read port
// Purpose: DEPTH x WIDTH array. Contents are never reset; only the read register is.
// Ports:
//   clk, rst_n         clock, async active-low reset (read register only)
//   we, waddr, wdata   synchronous write port
//   re, raddr          read enable/address; rdata updates the cycle after re
//   rdata              registered read data, holds when re is low
module lut_mem
  import lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int WIDTH  = LUT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_ctrl.sv
// rtl/lut_ctrl.sv - jump-target line table controller: boot load, br/dbg read arbitration
// Purpose: loads the whole table from a streaming port, then serves single-port reads to
//   the branch unit (priority) and debug port (starvation-protected), 1-cycle latency.
// Optional: define LUT_PARITY_EN to store an even-parity bit per entry and add rd_perr.
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   load_start, load_valid, load_data        load control and data stream
//   load_ready, load_done                    load accept, completion pulse
//   br_req, br_addr, br_gnt                  branch unit read request/grant
//   dbg_req, dbg_addr, dbg_gnt               debug read request/grant
//   rd_valid, rd_data, rd_src                read response (src 0 = br, 1 = dbg)
//   rd_perr                                  parity error with rd_valid (LUT_PARITY_EN only)
//   busy                                     high whenever not in RUN
module lut_ctrl
  import lut_pkg::*;
#(
  parameter int ADDR_W     = LUT_ADDR_W,
  parameter int DATA_W     = LUT_DATA_W,
  parameter int DEPTH      = 2**ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              br_req,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              br_gnt,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_src,
`ifdef LUT_PARITY_EN
  output logic              rd_perr,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
`ifdef LUT_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  lut_state_e        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  starve_cnt;

  logic              run_ok;
  logic              dbg_force;
  logic              wr_en;
  logic              last_wr;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  // A load_start in RUN takes effect this cycle, so no new read may be granted.
  assign run_ok    = (state == RUN) && !load_start;
  assign dbg_force = (starve_cnt >= CNT_W'(STARVE_MAX));
  assign dbg_gnt   = run_ok && dbg_req && (!br_req || dbg_force);
  assign br_gnt    = run_ok && br_req && !dbg_gnt;
  assign rd_en     = br_gnt || dbg_gnt;
  assign rd_addr   = dbg_gnt ? dbg_addr : br_addr;

  assign load_ready = (state == LOAD);
  assign busy       = (state != RUN);

  // load_start inside LOAD restarts at entry 0; a word offered in that same cycle lands there.
  assign wr_en   = (state == LOAD) && load_valid;
  assign wr_addr = load_start ? '0 : wr_ptr;
  assign last_wr = wr_en && (wr_addr == ADDR_W'(DEPTH - 1));

`ifdef LUT_PARITY_EN
  // Stored bit makes the total count of ones even; any odd total on read is an error.
  assign wr_word = {^load_data, load_data};
  assign rd_data = rd_word[DATA_W-1:0];
  assign rd_perr = rd_valid && (^rd_word);
`else
  assign wr_word = load_data;
  assign rd_data = rd_word;
`endif

  lut_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WIDTH  (MEM_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      starve_cnt <= '0;
      rd_valid   <= 1'b0;
      rd_src     <= SRC_BR;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      rd_valid  <= rd_en;
      if (rd_en) begin
        rd_src <= dbg_gnt ? SRC_DBG : SRC_BR;
      end

      // br_gnt with dbg_req high is exactly a contested cycle that dbg lost.
      if (!dbg_req || dbg_gnt) begin
        starve_cnt <= '0;
      end else if (br_gnt) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (load_start) begin
            state  <= LOAD;
            wr_ptr <= '0;
          end
        end
        LOAD: begin
          if (last_wr) begin
            state     <= RUN;
            wr_ptr    <= '0;
            load_done <= 1'b1;
          end else if (wr_en) begin
            wr_ptr <= wr_addr + 1'b1;
          end else if (load_start) begin
            wr_ptr <= '0;
          end
        end
        RUN: begin
          if (load_start) begin
            state  <= LOAD;
            wr_ptr <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_ctrl.sv
// tb/tb_lut_ctrl.sv - self-checking bench for lut_ctrl
module tb_lut_ctrl;

  localparam int SMAX = 4;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        br_req;
  logic [7:0]  br_addr;
  logic        br_gnt;
  logic        dbg_req;
  logic [7:0]  dbg_addr;
  logic        dbg_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_src;
  logic        busy;
`ifdef LUT_PARITY_EN
  logic        rd_perr;
`endif

  lut_ctrl #(
    .ADDR_W     (8),
    .DATA_W     (16),
    .DEPTH      (256),
    .STARVE_MAX (SMAX)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .br_req     (br_req),
    .br_addr    (br_addr),
    .br_gnt     (br_gnt),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_gnt    (dbg_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_src     (rd_src),
`ifdef LUT_PARITY_EN
    .rd_perr    (rd_perr),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ref_mem [256];

  typedef struct {
    logic        br_req;
    logic [7:0]  br_addr;
    logic        dbg_req;
    logic [7:0]  dbg_addr;
    logic        e_br;
    logic        e_dbg;
    logic [15:0] e_data;
    logic        e_src;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat_val(input int p, input int a);
    logic [15:0] a16;
    a16 = 16'(a);
    case (p)
      0:       return a16 ^ 16'hA5A5;
      1:       return ~a16;
      default: return 16'(a * 7);
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    next_cycle();
    load_start = 1'b0;
  endtask

  task automatic stream(input int n, input int p, input bit check_done);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = pat_val(p, i);
      @(negedge clk);
      chk("load_ready", 32'(load_ready), 32'd1);
      ref_mem[i] = load_data;
      next_cycle();
    end
    load_valid = 1'b0;
    if (check_done) begin
      @(negedge clk);
      chk("load_done_pulse", 32'(load_done), 32'd1);
      chk("busy_after_load", 32'(busy), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("load_done_single", 32'(load_done), 32'd0);
      next_cycle();
    end
  endtask

  initial begin
    logic       br_r, dbg_r, eb, ed_g, ev, es;
    logic [7:0] br_a, dbg_a;
    logic [15:0] edat;
    int lost;

    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    br_req = 1'b1; br_addr = 8'h10; dbg_req = 1'b1; dbg_addr = 8'h20;

    // Reset state: outputs zero, busy high, no grants in IDLE.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_src", 32'(rd_src), 32'd0);
    chk("rst_br_gnt", 32'(br_gnt), 32'd0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
`ifdef LUT_PARITY_EN
    chk("rst_rd_perr", 32'(rd_perr), 32'd0);
`endif
    rst_n = 1'b1; br_req = 1'b0; dbg_req = 1'b0;
    next_cycle();

    start_load();
    stream(256, 0, 1'b1);

    // Single-cycle table vectors, each isolated by an idle cycle.
    vt[0] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 16'hA5B5, 1'b0};
    vt[1] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 16'hA596, 1'b1};
    vt[2] = '{1'b1, 8'hFF, 1'b1, 8'h01, 1'b1, 1'b0, 16'hA55A, 1'b0};
    vt[3] = '{1'b0, 8'h44, 1'b0, 8'h55, 1'b0, 1'b0, 16'h0000, 1'b0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 16'hA525, 1'b1};
    for (int v = 0; v < 5; v++) begin
      br_req = vt[v].br_req; br_addr = vt[v].br_addr;
      dbg_req = vt[v].dbg_req; dbg_addr = vt[v].dbg_addr;
      @(negedge clk);
      chk("vec_br_gnt", 32'(br_gnt), 32'(vt[v].e_br));
      chk("vec_dbg_gnt", 32'(dbg_gnt), 32'(vt[v].e_dbg));
      next_cycle();
      br_req = 1'b0; dbg_req = 1'b0;
      @(negedge clk);
      chk("vec_rd_valid", 32'(rd_valid), 32'(vt[v].e_br | vt[v].e_dbg));
      if (vt[v].e_br | vt[v].e_dbg) begin
        chk("vec_rd_data", 32'(rd_data), 32'(vt[v].e_data));
        chk("vec_rd_src", 32'(rd_src), 32'(vt[v].e_src));
      end
      next_cycle();
    end

    // Contention for 10 cycles: dbg wins only on the 5th and 10th.
    br_req = 1'b1; br_addr = 8'h10; dbg_req = 1'b1; dbg_addr = 8'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_br_gnt", 32'(br_gnt), 32'((i != 4) && (i != 9)));
      chk("starve_dbg_gnt", 32'(dbg_gnt), 32'((i == 4) || (i == 9)));
      if (i > 0) begin
        chk("starve_rd_valid", 32'(rd_valid), 32'd1);
        chk("starve_rd_src", 32'(rd_src), 32'(i == 5));
      end
      next_cycle();
    end
    br_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    chk("starve_last_src", 32'(rd_src), 32'd1);
    chk("starve_last_data", 32'(rd_data), 32'h0000A585);
    next_cycle();

    // load_start in RUN during a granted read.
    br_req = 1'b1; br_addr = 8'h10;
    @(negedge clk);
    chk("ls_first_gnt", 32'(br_gnt), 32'd1);
    next_cycle();
    load_start = 1'b1; br_addr = 8'h11;
    @(negedge clk);
    chk("ls_no_gnt", 32'(br_gnt), 32'd0);
    chk("ls_rd_valid", 32'(rd_valid), 32'd1);
    chk("ls_rd_data", 32'(rd_data), 32'hA5B5);
    chk("ls_rd_src", 32'(rd_src), 32'd0);
    next_cycle();
    load_start = 1'b0;
    #1;
    chk("ls_load_ready", 32'(load_ready), 32'd1);
    chk("ls_busy", 32'(busy), 32'd1);
    chk("ls_no_rd_valid", 32'(rd_valid), 32'd0);
    chk("ls_no_gnt_load", 32'(br_gnt), 32'd0);
    br_req = 1'b0;

    // Reset mid-load after 100 words, then a fresh full load.
    stream(100, 1, 1'b0);
    rst_n = 1'b0;
    br_req = 1'b1; dbg_req = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_load_ready", 32'(load_ready), 32'd0);
    chk("mid_rst_br_gnt", 32'(br_gnt), 32'd0);
    chk("mid_rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("idle_br_gnt", 32'(br_gnt), 32'd0);
    chk("idle_dbg_gnt", 32'(dbg_gnt), 32'd0);
    next_cycle();
    br_req = 1'b0; dbg_req = 1'b0;
    start_load();
    stream(256, 2, 1'b1);

    // Randomised traffic against the reference model. Requesters hold until granted.
    lost = 0; ev = 1'b0; es = 1'b0; edat = '0;
    br_r = 1'b0; dbg_r = 1'b0; br_a = '0; dbg_a = '0;
    for (int n = 0; n < 400; n++) begin
      br_req = br_r; br_addr = br_a; dbg_req = dbg_r; dbg_addr = dbg_a;
      ed_g = dbg_r && (!br_r || lost >= SMAX);
      eb   = br_r && !ed_g;
      @(negedge clk);
      chk("rnd_br_gnt", 32'(br_gnt), 32'(eb));
      chk("rnd_dbg_gnt", 32'(dbg_gnt), 32'(ed_g));
      chk("rnd_rd_valid", 32'(rd_valid), 32'(ev));
      if (ev) begin
        chk("rnd_rd_data", 32'(rd_data), 32'(edat));
        chk("rnd_rd_src", 32'(rd_src), 32'(es));
      end
      ev = eb || ed_g;
      if (ev) begin
        edat = ed_g ? ref_mem[dbg_a] : ref_mem[br_a];
        es   = ed_g;
      end
      if (!dbg_r || ed_g) lost = 0;
      else if (br_r) lost = lost + 1;
      if (!br_r || eb) begin
        br_r = ($urandom_range(0, 3) != 0);
        br_a = 8'($urandom);
      end
      if (!dbg_r || ed_g) begin
        dbg_r = ($urandom_range(0, 3) != 0);
        dbg_a = 8'($urandom);
      end
      next_cycle();
    end
    br_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    chk("rnd_tail_valid", 32'(rd_valid), 32'(ev));
    if (ev) chk("rnd_tail_data", 32'(rd_data), 32'(edat));
    next_cycle();

`ifdef LUT_PARITY_EN
    // Corrupt one stored bit and read it back.
    u_dut.u_mem.mem[8'h20][3] = ~u_dut.u_mem.mem[8'h20][3];
    br_req = 1'b1; br_addr = 8'h20;
    next_cycle();
    br_addr = 8'h21;
    @(negedge clk);
    chk("perr_valid", 32'(rd_valid), 32'd1);
    chk("perr_flag", 32'(rd_perr), 32'd1);
    next_cycle();
    br_req = 1'b0;
    @(negedge clk);
    chk("perr_clean_valid", 32'(rd_valid), 32'd1);
    chk("perr_clean_flag", 32'(rd_perr), 32'd0);
    next_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
